// File: rtl/tag_fifo_if.sv
// ----------------------------------------------------------------------------
// tag_fifo_if
//   Dispatch/commit side bundle of the physical tag free-list.
//
//   Signals:
//     dispatch_tag        FIFO -> dispatch : tag at head (fall-through)
//     dispatch_tag_valid  FIFO -> dispatch : head tag is valid
//     dispatch_tag_ren    dispatch -> FIFO : consume head tag this cycle
//     commit_tag          commit -> FIFO   : tag being returned
//     commit_tag_wen      commit -> FIFO   : push commit_tag this cycle
//     tagfifo_full        FIFO -> user     : all tags present
//     tagfifo_empty       FIFO -> user     : no tags present
//     tagfifo_count       FIFO -> user     : number of tags held
//     tagfifo_err         FIFO -> user     : sticky protocol error
//
//   Modports:
//     master : the dispatch/commit logic driving requests
//     slave  : the tag FIFO itself
// ----------------------------------------------------------------------------
interface tag_fifo_if #(
    parameter int TAG_WIDTH = 6
);
    logic [TAG_WIDTH-1:0] dispatch_tag;
    logic                 dispatch_tag_valid;
    logic                 dispatch_tag_ren;
    logic [TAG_WIDTH-1:0] commit_tag;
    logic                 commit_tag_wen;
    logic                 tagfifo_full;
    logic                 tagfifo_empty;
    logic [TAG_WIDTH:0]   tagfifo_count;
    logic                 tagfifo_err;

    modport master (
        input  dispatch_tag,
        input  dispatch_tag_valid,
        output dispatch_tag_ren,
        output commit_tag,
        output commit_tag_wen,
        input  tagfifo_full,
        input  tagfifo_empty,
        input  tagfifo_count,
        input  tagfifo_err
    );

    modport slave (
        output dispatch_tag,
        output dispatch_tag_valid,
        input  dispatch_tag_ren,
        input  commit_tag,
        input  commit_tag_wen,
        output tagfifo_full,
        output tagfifo_empty,
        output tagfifo_count,
        output tagfifo_err
    );
endinterface : tag_fifo_if

// File: rtl/tag_fifo.sv
// ----------------------------------------------------------------------------
// tag_fifo
//   Circular free-list of physical result tags feeding dispatch. Out of reset
//   it holds every tag 0..DEPTH-1 in order; dispatch pops the head tag,
//   commit pushes retired tags back. Guarantees unique in-flight tags as long
//   as commit returns each tag exactly once.
//
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous reset, active-low (0 = reset)
//     bus    tag_fifo_if.slave : dispatch head/ren, commit tag/wen,
//            full/empty/count status and sticky error flag
// ----------------------------------------------------------------------------
module tag_fifo #(
    parameter int TAG_WIDTH = 6,
    parameter int DEPTH     = 64    // must equal 2**TAG_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    tag_fifo_if.slave      bus
);
    localparam int PTR_W = TAG_WIDTH + 1;

    logic [TAG_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]     r_rptr;
    logic [PTR_W-1:0]     r_wptr;
    logic                 r_err;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_pop_err;
    logic w_push_err;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign w_empty = (r_rptr == r_wptr);
    assign w_full  = (r_rptr[TAG_WIDTH-1:0] == r_wptr[TAG_WIDTH-1:0]) &&
                     (r_rptr[TAG_WIDTH] != r_wptr[TAG_WIDTH]);

    assign w_pop      = bus.dispatch_tag_ren && !w_empty;
    // At full, a simultaneous pop frees the slot the push lands in.
    assign w_push     = bus.commit_tag_wen && (!w_full || bus.dispatch_tag_ren);
    // A pop on empty is only an error if no push rescues the cycle.
    assign w_pop_err  = bus.dispatch_tag_ren && w_empty && !bus.commit_tag_wen;
    assign w_push_err = bus.commit_tag_wen && w_full && !bus.dispatch_tag_ren;

    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the array is reset on purpose -- the free-list must start
            // holding every tag, so this storage is state, not a plain RAM.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= TAG_WIDTH'(i);
            end
            r_rptr <= '0;
            r_wptr <= PTR_W'(DEPTH);
            r_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every read in this block
            // seeing pre-edge values, so pop and push on one edge don't race.
            if (w_push) begin
                r_mem[r_wptr[TAG_WIDTH-1:0]] <= bus.commit_tag;
                r_wptr                       <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_pop_err || w_push_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.dispatch_tag       = r_mem[r_rptr[TAG_WIDTH-1:0]];
    assign bus.dispatch_tag_valid = !w_empty;
    assign bus.tagfifo_full       = w_full;
    assign bus.tagfifo_empty      = w_empty;
    assign bus.tagfifo_count      = r_wptr - r_rptr;
    assign bus.tagfifo_err        = r_err;

endmodule : tag_fifo

// File: tb/tb_tag_fifo.sv
// ----------------------------------------------------------------------------
// tb_tag_fifo
//   Self-checking bench for tag_fifo. A queue-based model of the free-list
//   tracks which tags are held and in what order; every cycle all outputs are
//   compared against it. Directed scenarios cover reset, drain, wrap-around,
//   simultaneous pop/push at full and empty, and error stickiness; a
//   randomized phase follows.
// ----------------------------------------------------------------------------
module tb_tag_fifo;
    localparam int TW = 6;
    localparam int D  = 64;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    tag_fifo_if #(.TAG_WIDTH(TW)) bus ();

    tag_fifo #(.TAG_WIDTH(TW), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [TW-1:0] model_q [$];
    bit            model_err;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, obs, exp, $time);
        end
    endtask

    // Compare every observable output against the model.
    task automatic check_all();
        int sz;
        sz = model_q.size();
        check("count", 32'(bus.tagfifo_count), 32'(sz));
        check("full",  32'(bus.tagfifo_full),  32'(sz == D));
        check("empty", 32'(bus.tagfifo_empty), 32'(sz == 0));
        check("valid", 32'(bus.dispatch_tag_valid), 32'(sz != 0));
        check("err",   32'(bus.tagfifo_err),   32'(model_err));
        if (sz != 0) begin
            check("head", 32'(bus.dispatch_tag), 32'(model_q[0]));
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, sample after.
    task automatic cycle(input bit ren, input bit wen, input logic [TW-1:0] tag,
                         input bit rst_n = 1'b1);
        bit is_empty;
        bit is_full;
        reset                = rst_n;
        bus.dispatch_tag_ren = ren;
        bus.commit_tag_wen   = wen;
        bus.commit_tag       = tag;
        @(posedge clk);
        if (!rst_n) begin
            model_q.delete();
            for (int i = 0; i < D; i++) model_q.push_back(TW'(i));
            model_err = 1'b0;
        end else begin
            is_empty = (model_q.size() == 0);
            is_full  = (model_q.size() == D);
            if (ren && is_empty && !wen) model_err = 1'b1;
            if (wen && is_full && !ren)  model_err = 1'b1;
            if (ren && !is_empty) void'(model_q.pop_front());
            if (wen && (!is_full || ren)) model_q.push_back(tag);
        end
        #1;
        check_all();
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        logic [TW-1:0] exp_tag;
        int            p_r;
        int            p_w;

        reset                = 1'b0;
        bus.dispatch_tag_ren = 1'b0;
        bus.commit_tag_wen   = 1'b0;
        bus.commit_tag       = '0;
        model_err            = 1'b0;

        // Reset state and full drain in order.
        do_reset();
        check("rst_count", 32'(bus.tagfifo_count), 32'd64);
        check("rst_head",  32'(bus.dispatch_tag),  32'd0);
        check("rst_full",  32'(bus.tagfifo_full),  32'd1);
        for (int i = 0; i < D; i++) begin
            check("drain_head", 32'(bus.dispatch_tag), 32'(i));
            cycle(1'b1, 1'b0, '0);
        end
        check("drain_empty", 32'(bus.tagfifo_empty), 32'd1);
        check("drain_valid", 32'(bus.dispatch_tag_valid), 32'd0);

        // Push 17, 3, 42 from empty, then pop them back.
        cycle(1'b0, 1'b1, TW'(17));
        cycle(1'b0, 1'b1, TW'(3));
        cycle(1'b0, 1'b1, TW'(42));
        check("p3_count", 32'(bus.tagfifo_count), 32'd3);
        check("p3_h0", 32'(bus.dispatch_tag), 32'd17);
        cycle(1'b1, 1'b0, '0);
        check("p3_h1", 32'(bus.dispatch_tag), 32'd3);
        cycle(1'b1, 1'b0, '0);
        check("p3_h2", 32'(bus.dispatch_tag), 32'd42);
        cycle(1'b1, 1'b0, '0);
        check("p3_empty", 32'(bus.tagfifo_empty), 32'd1);
        check("p3_err",   32'(bus.tagfifo_err),   32'd0);

        // Simultaneous pop+push at full.
        do_reset();
        cycle(1'b1, 1'b1, TW'(9));
        check("full_rw_count", 32'(bus.tagfifo_count), 32'd64);
        check("full_rw_head",  32'(bus.dispatch_tag),  32'd1);
        for (int i = 0; i < 63; i++) cycle(1'b1, 1'b0, '0);
        check("full_rw_tail", 32'(bus.dispatch_tag), 32'd9);

        // Simultaneous pop+push at empty.
        cycle(1'b1, 1'b0, '0);
        check("pre_empty", 32'(bus.tagfifo_empty), 32'd1);
        cycle(1'b1, 1'b1, TW'(5));
        check("empty_rw_count", 32'(bus.tagfifo_count), 32'd1);
        check("empty_rw_err",   32'(bus.tagfifo_err),   32'd0);
        check("empty_rw_head",  32'(bus.dispatch_tag),  32'd5);

        // Pointer wrap-around.
        do_reset();
        for (int i = 0; i < 60; i++) cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < 60; i++) cycle(1'b0, 1'b1, TW'(i));
        for (int k = 0; k < 10; k++) begin
            exp_tag = TW'((60 + k) % 64);
            check("wrap_head", 32'(bus.dispatch_tag), 32'(exp_tag));
            cycle(1'b1, 1'b0, '0);
        end
        check("wrap_count", 32'(bus.tagfifo_count), 32'd54);

        // Pop on empty sets a sticky error.
        while (model_q.size() != 0) cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        check("pop_empty_err", 32'(bus.tagfifo_err), 32'd1);
        for (int i = 0; i < 8; i++) cycle(i[0], 1'b1, TW'(i));
        check("err_sticky", 32'(bus.tagfifo_err), 32'd1);

        // Push on full without pop, then mid-stream reset.
        do_reset();
        check("rst_clears_err", 32'(bus.tagfifo_err), 32'd0);
        cycle(1'b0, 1'b1, TW'(7));
        check("push_full_count", 32'(bus.tagfifo_count), 32'd64);
        check("push_full_err",   32'(bus.tagfifo_err),   32'd1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, TW'(33), 1'b0);
        check("mid_rst_err",   32'(bus.tagfifo_err),   32'd0);
        check("mid_rst_count", 32'(bus.tagfifo_count), 32'd64);
        check("mid_rst_head",  32'(bus.dispatch_tag),  32'd0);

        // Randomized traffic with shifting pop/push bias to reach both ends.
        for (int blk = 0; blk < 16; blk++) begin
            p_r = (blk % 2 == 0) ? 75 : 30;
            p_w = (blk % 2 == 0) ? 30 : 75;
            for (int i = 0; i < 200; i++) begin
                cycle($urandom_range(99) < p_r,
                      $urandom_range(99) < p_w,
                      TW'($urandom_range(D - 1)),
                      $urandom_range(499) != 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_tag_fifo

// File: doc/tag_fifo.md
Name: tag_fifo

Overview:
- Circular free-list of physical result tags, sitting directly upstream of the register status table (rst).
- Supplies the next free tag to dispatch; dispatch writes that tag into rst via dispatch_tag.
- Takes tags back when their instructions commit.
- Guarantees every in-flight destination has a unique tag for CDB broadcast and rst clear matching.

Parameters:
- TAG_WIDTH, 6, tag width in bits; must match rst dispatch_tag/cdb_tag width.
- DEPTH, 64, number of tags managed; must equal 2**TAG_WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous reset, active-low (0 = reset)
- dispatch_tag  output  TAG_WIDTH  tag at FIFO head (first-word fall-through)
- dispatch_tag_valid  output  1  head tag is valid (FIFO not empty)
- dispatch_tag_ren  input  1  dispatch consumes head tag this cycle
- commit_tag  input  TAG_WIDTH  tag being returned by commit
- commit_tag_wen  input  1  push commit_tag this cycle
- tagfifo_full  output  1  all DEPTH tags present
- tagfifo_empty  output  1  no tags present
- tagfifo_count  output  TAG_WIDTH+1  number of tags held, 0..DEPTH
- tagfifo_err  output  1  sticky protocol error flag

Behaviour:
- Storage: DEPTH x TAG_WIDTH register array.
- Pointers: rptr and wptr, each TAG_WIDTH+1 bits; the MSB is the wrap bit.
- Empty when rptr == wptr. Full when the low bits are equal and the MSBs differ.
- Reset (reset==0 at posedge clk), regardless of in-flight activity:
  - mem[i] = i for i = 0..DEPTH-1; rptr = 0; wptr = DEPTH (wrap bit 1, low bits 0).
  - Result: full=1, empty=0, count=DEPTH, dispatch_tag=0, dispatch_tag_valid=1, err=0.
  - dispatch_tag_ren and commit_tag_wen are ignored during reset.
- Read path:
  - dispatch_tag = mem[rptr low bits] combinationally; dispatch_tag_valid = !empty.
  - Pop happens at posedge when dispatch_tag_ren && !empty; rptr increments by 1, wrapping naturally.
  - New head is visible the cycle after the pop.
- Write path: push happens at posedge when commit_tag_wen and the push is accepted (rules below). The write goes to mem[wptr low bits] and wptr increments by 1.
- Simultaneous pop and push:
  - Not empty, not full: both occur; count unchanged.
  - Full: both occur; the pop frees a slot; count stays DEPTH.
  - Empty: push occurs, pop ignored, no err; count becomes 1; the pushed tag is visible at the head next cycle (no same-cycle bypass).
- Illegal operations (sticky tagfifo_err, cleared only by reset):
  - Pop when empty: ignored, err set.
  - Push when full without a simultaneous pop: ignored, err set.
- Count and flags are registered-equivalent functions of the pointers: count = wptr - rptr (TAG_WIDTH+1 bit modular subtraction); full and empty as defined above.
- Duplicate-tag detection is out of scope; commit is responsible for returning each tag exactly once.
- Latency: pop-to-new-head 1 cycle; push-to-visible 1 cycle when empty.

Test Plan:
- Reset release -> count=64, full=1, dispatch_tag=0, valid=1; pop every cycle for 64 cycles -> tags 0..63 in order, then empty=1, valid=0, count=0, full=0.
- From empty, push 17, 3, 42 on consecutive cycles -> count=3; pop three times -> dispatch_tag reads 17, 3, 42; then empty=1, err=0.
- At full, assert ren and wen (commit_tag=9) together -> count stays 64; head advances to 1; after 63 more pops the head is 9.
- At empty, assert ren and wen (commit_tag=5) together -> count=1, err=0, dispatch_tag=5 next cycle.
- Pointer wrap-around: pop 60, push 60 (tags 0..59), pop 10 more -> the ten pops read 60,61,62,63,0,1,2,3,4,5; count=54.
- Error and reset: pop when empty -> err=1 and stays 1 across later legal traffic; at full, push without pop -> count unchanged, err=1; drive reset=0 for one cycle mid-stream -> err=0, count=64, dispatch_tag=0.
